// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer: LCD power-up wait, fixed HD44780 8-bit init, then round-robin byte writes
//
// Ports:
//   clk, nRst                  clock (rising edge), asynchronous active-low reset
//   req0/rs0/data0             requester 0: request (held until ack0), register select, byte
//   req1/rs1/data1             requester 1: same as requester 0
//   ack0, ack1                 one-cycle pulse when that requester's write has completed
//   init_done                  sticky, set once the init sequence has been written
//   err                        sticky watchdog timeout flag
//   lcd_nCS/lcd_nWR/lcd_nRD    controller strobes (active-low; nRD is held high)
//   lcd_rs, lcd_data           register select and byte presented to the controller
//   lcd_rdy                    controller RDY: falls when a transaction starts, rises when done
//
// Optional build macro LCD_SEQ_TIMEOUT_EN enables the per-transaction watchdog of
// TIMEOUT_CYCLES; without it err is constant 0 and the RDY waits are unbounded.
module lcd_write_sequencer #(
    parameter int PWRUP_CYCLES   = 750000,
    parameter int CNT_W          = 20,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       req0,
    input  logic       req1,
    input  logic       rs0,
    input  logic       rs1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       init_done,
    output logic       err,
    output logic       lcd_nCS,
    output logic       lcd_nWR,
    output logic       lcd_nRD,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    input  logic       lcd_rdy
);
    typedef enum logic [2:0] {PWRUP, ISSUE, WAIT_LO, WAIT_HI, DONE, IDLE} state_t;

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWRUP_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic             init_q;
    logic             done_q;
    logic             err_q;
    logic             prio_q;
    logic             gnt_q;
    logic             strobe_q;
    logic             ack0_q;
    logic             ack1_q;
    logic             rs_q;
    logic [7:0]       data_q;
    logic             pick1;
    logic             timeout;
    logic             finish;

    function automatic logic [7:0] rom(input logic [1:0] i);
        return i == 2'd0 ? 8'h38 : i == 2'd1 ? 8'h0C : i == 2'd2 ? 8'h01 : 8'h06;
    endfunction

    // prio_q names the requester that wins when both are pending
    assign pick1 = req1 && (!req0 || prio_q);

`ifdef LCD_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // counter is 1 in the first wait cycle, so DONE lands TIMEOUT_CYCLES cycles after ISSUE
    assign timeout = (state_q == WAIT_LO || state_q == WAIT_HI) && cnt_q == TO_LAST;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // a transaction ends on RDY high in WAIT_HI, or on the watchdog
    assign finish = timeout || (state_q == WAIT_HI && lcd_rdy);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= PWRUP;
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            init_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            prio_q   <= 1'b0;
            gnt_q    <= 1'b0;
            strobe_q <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            strobe_q <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            if (finish) begin
                state_q <= DONE;
                ack0_q  <= !init_q && !gnt_q;
                ack1_q  <= !init_q && gnt_q;
                err_q   <= err_q || timeout;
            end else begin
                case (state_q)
                    PWRUP: begin
                        if (cnt_q == PWR_LAST) begin
                            state_q  <= ISSUE;
                            strobe_q <= 1'b1;
                            init_q   <= 1'b1;
                            idx_q    <= 2'd0;
                            rs_q     <= 1'b0;
                            data_q   <= rom(2'd0);
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ISSUE: begin
                        state_q <= WAIT_LO;
                        cnt_q   <= CNT_W'(1);
                    end
                    WAIT_LO: begin
                        state_q <= lcd_rdy ? WAIT_LO : WAIT_HI;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                    WAIT_HI: begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    DONE: begin
                        if (init_q && idx_q != 2'd3) begin
                            state_q  <= ISSUE;
                            strobe_q <= 1'b1;
                            idx_q    <= idx_q + 2'd1;
                            data_q   <= rom(idx_q + 2'd1);
                        end else begin
                            state_q <= IDLE;
                            done_q  <= done_q || init_q;
                            init_q  <= 1'b0;
                        end
                    end
                    IDLE: begin
                        if (done_q && (req0 || req1)) begin
                            state_q  <= ISSUE;
                            strobe_q <= 1'b1;
                            gnt_q    <= pick1;
                            prio_q   <= !pick1;
                            rs_q     <= pick1 ? rs1 : rs0;
                            data_q   <= pick1 ? data1 : data0;
                        end
                    end
                    default: state_q <= PWRUP;
                endcase
            end
        end
    end

    assign lcd_nCS   = !strobe_q;
    assign lcd_nWR   = !strobe_q;
    assign lcd_nRD   = 1'b1;
    assign lcd_rs    = rs_q;
    assign lcd_data  = data_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign init_done = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_lcd_write_sequencer.sv
// tb_lcd_write_sequencer: scoreboard bench for the LCD write sequencer
module tb_lcd_write_sequencer;
    localparam int PWR = 10;
    localparam int TO  = 16;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic       rs0 = 1'b0;
    logic       rs1 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       lcd_rdy = 1'b1;
    logic       ack0, ack1, init_done, err;
    logic       lcd_nCS, lcd_nWR, lcd_nRD, lcd_rs;
    logic [7:0] lcd_data;

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         rise_cyc = 0;
    int         n_strobe = 0;
    bit         never_rise = 1'b0;
    bit         prev_rdy = 1'b1;
    bit         prev_cs = 1'b0;
    logic [8:0] exp_q[$];
    logic [1:0] ack_q[$];

    lcd_write_sequencer #(.PWRUP_CYCLES(PWR), .CNT_W(20), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .nRst(nRst),
        .req0(req0), .req1(req1), .rs0(rs0), .rs1(rs1), .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1), .init_done(init_done), .err(err),
        .lcd_nCS(lcd_nCS), .lcd_nWR(lcd_nWR), .lcd_nRD(lcd_nRD),
        .lcd_rs(lcd_rs), .lcd_data(lcd_data), .lcd_rdy(lcd_rdy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp_q.size() != 0 || ack_q.size() != 0); i++) tick();
        check("queues_drained", exp_q.size() + ack_q.size(), 0);
    endtask

    task automatic wait_init(output int early);
        early = 0;
        for (int i = 0; i < 300 && !init_done; i++) begin
            tick();
            if ((ack0 || ack1) && !init_done) early++;
        end
    endtask

    // controller model: RDY drops 3 cycles after the strobe and rises 5 cycles later
    initial forever begin
        @(negedge clk);
        if (nRst && !lcd_nWR) begin
            repeat (3) @(negedge clk);
            lcd_rdy = 1'b0;
            if (!never_rise) begin
                repeat (5) @(negedge clk);
                lcd_rdy = 1'b1;
            end
        end
    end

    // monitor: pops the scoreboard whenever a strobe or ack is presented
    initial forever begin
        tick();
        if (lcd_rdy && !prev_rdy) rise_cyc = cyc;
        prev_rdy = lcd_rdy;
        if (!lcd_nCS) begin
            n_strobe++;
            check("strobe_nwr", lcd_nWR, 1'b0);
            check("strobe_nrd", lcd_nRD, 1'b1);
            check("strobe_one_cycle", prev_cs, 1'b0);
            check("strobe_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("strobe_rs_data", {lcd_rs, lcd_data}, exp_q.pop_front());
        end
        prev_cs = !lcd_nCS;
        if (ack0 || ack1) begin
            check("ack_expected", ack_q.size() != 0, 1'b1);
            if (ack_q.size() != 0) check("ack_id", {ack1, ack0}, ack_q.pop_front());
            if (!never_rise) check("ack_after_rdy", cyc - rise_cyc, 1);
        end
    end

    initial begin
        int n;
        int s;
        int early;
        // reset values
        repeat (3) tick();
        check("rst_ncs", lcd_nCS, 1'b1);
        check("rst_nwr", lcd_nWR, 1'b1);
        check("rst_nrd", lcd_nRD, 1'b1);
        check("rst_rs_data", {lcd_rs, lcd_data}, 9'h000);
        check("rst_acks", {ack1, ack0}, 2'b00);
        check("rst_init_done", init_done, 1'b0);
        check("rst_err", err, 1'b0);

        // init sequence with req1 pending during power-up
        push_init();
        exp_q.push_back(9'h155);
        ack_q.push_back(2'b10);
        @(negedge clk);
        nRst = 1'b1;
        n = 1;
        for (int i = 0; i < 60; i++) begin
            tick();
            n++;
            if (n == 3) begin
                req1 = 1'b1;
                rs1 = 1'b1;
                data1 = 8'h55;
            end
            if (!lcd_nCS) break;
        end
        check("first_strobe_cycle", n, PWR + 1);
        wait_init(early);
        check("init_done_set", init_done, 1'b1);
        check("no_ack_before_init", early, 0);
        check("init_strobe_count", n_strobe, 4);
        for (int i = 0; i < 100 && !ack1; i++) tick();
        check("ack1_seen", ack1, 1'b1);
        req1 = 1'b0;
        drain();

        // both requesters held: grants must alternate 0,1,0,1
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h10;
        req1 = 1'b1; rs1 = 1'b0; data1 = 8'h20;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(9'h110);
            ack_q.push_back(2'b01);
            exp_q.push_back(9'h020);
            ack_q.push_back(2'b10);
        end
        n = 0;
        for (int i = 0; i < 400 && n < 4; i++) begin
            tick();
            n += int'(ack0) + int'(ack1);
            req0 = !ack0;
            req1 = !ack1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("rr_ack_count", n, 4);
        drain();

        // single data write from requester 0
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
        exp_q.push_back(9'h141);
        ack_q.push_back(2'b01);
        for (int i = 0; i < 100 && !ack0; i++) tick();
        check("ack0_seen", ack0, 1'b1);
        req0 = 1'b0;
        drain();
        check("err_clear", err, 1'b0);

        // reset while in WAIT_HI of a normal write: nothing is acked, init reruns
        req0 = 1'b1; rs0 = 1'b0; data0 = 8'h77;
        exp_q.push_back(9'h077);
        for (int i = 0; i < 50 && lcd_nCS; i++) tick();
        for (int i = 0; i < 50 && lcd_rdy; i++) tick();
        tick();
        req0 = 1'b0;
        nRst = 1'b0;
        #1;
        check("mid_rst_ncs", lcd_nCS, 1'b1);
        check("mid_rst_nwr", lcd_nWR, 1'b1);
        check("mid_rst_init_done", init_done, 1'b0);
        check("mid_rst_ack0", ack0, 1'b0);
        check("mid_rst_data", {lcd_rs, lcd_data}, 9'h000);
        tick();
        push_init();
        s = n_strobe;
        nRst = 1'b1;
        wait_init(early);
        check("reinit_done", init_done, 1'b1);
        check("reinit_strobes", n_strobe - s, 4);
        drain();

`ifdef LCD_SEQ_TIMEOUT_EN
        // watchdog: RDY never rises, ack still pulses TO cycles after ISSUE
        never_rise = 1'b1;
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h99;
        exp_q.push_back(9'h199);
        ack_q.push_back(2'b01);
        for (int i = 0; i < 50 && lcd_nCS; i++) tick();
        s = cyc;
        for (int i = 0; i < 100 && !ack0; i++) tick();
        check("timeout_ack_delay", cyc - s, TO);
        check("timeout_err", err, 1'b1);
        req0 = 1'b0;
        tick();
        lcd_rdy = 1'b1;
        prev_rdy = 1'b1;
        never_rise = 1'b0;
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'hAB;
        exp_q.push_back(9'h1AB);
        ack_q.push_back(2'b10);
        for (int i = 0; i < 100 && !ack1; i++) tick();
        check("after_timeout_ack1", ack1, 1'b1);
        req1 = 1'b0;
        drain();
        check("err_sticky", err, 1'b1);
`else
        check("err_tied_low", err, 1'b0);
`endif
        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_write_sequencer.md
# lcd_write_sequencer

Sequencer and arbiter in front of the LCD bus controller, which is driven through nCS/nWR/nRD/RS and reports completion on RDY. After reset it waits out the LCD power-up delay, then issues the fixed 8-bit HD44780 init sequence. It then shares the controller between two write requesters with round-robin arbitration, one byte per handshake. Sits between the EPC-side register logic, a local text engine and the LCD controller.

## Interface
- PWRUP_CYCLES, 750000, power-up wait in clk cycles (15 ms @ 50 MHz); must be ≥ 1
- CNT_W, 20, width of the shared delay/timeout counter; must hold PWRUP_CYCLES and TIMEOUT_CYCLES
- TIMEOUT_CYCLES, 4096, watchdog limit per transaction (used only with LCD_SEQ_TIMEOUT_EN)
- clk  in  1  system clock, all logic on rising edge
- nRst  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  write request, held high until matching ack
- rs0 / rs1  in  1  register select for that request (0 = command, 1 = data)
- data0 / data1  in  8  byte to write
- ack0 / ack1  out  1  one-cycle pulse when that request's write has completed
- init_done  out  1  high once the init sequence finishes; sticky until reset
- err  out  1  sticky timeout flag (constant 0 without LCD_SEQ_TIMEOUT_EN)
- lcd_nCS, lcd_nWR  out  1  strobes to controller, active-low
- lcd_nRD  out  1  held 1 (reads never issued)
- lcd_rs  out  1  RS to controller
- lcd_data  out  8  byte to controller
- lcd_rdy  in  1  controller RDY; falls when a transaction starts, rises when LCD busy clears

## Operation
- Reset values: lcd_nCS=1, lcd_nWR=1, lcd_nRD=1, lcd_rs=0, lcd_data=0x00, ack0=ack1=0, init_done=0, err=0, state PWRUP, counter 0, rr pointer = req0.
- States: PWRUP, ISSUE, WAIT_LO, WAIT_HI, DONE, IDLE. An init flag and a 2-bit ROM index track the init phase.
- PWRUP: count to PWRUP_CYCLES-1, then load ROM[0] and go to ISSUE with init flag set.
- Init ROM (all rs=0): 0x38, 0x0C, 0x01, 0x06.
- ISSUE: lcd_nCS=lcd_nWR=0 for exactly one cycle, then WAIT_LO.
- WAIT_LO: stay until lcd_rdy==0, then WAIT_HI.
- WAIT_HI: stay until lcd_rdy==1, then DONE.
- DONE, init phase: if index<3, increment index, load the next ROM byte and go to ISSUE. If index==3, set init_done and go to IDLE.
- DONE, normal phase: pulse ackN for the granted requester and go to IDLE.
- IDLE: arbitrate only when init_done=1. Requests during init are not acked and wait.
  - One request pending: grant it.
  - Both pending: grant the requester not granted last.
  - The rr pointer updates on each grant.
- Grant: capture rsN/dataN into lcd_rs/lcd_data and go to ISSUE. Later changes on rsN/dataN are ignored.
- Requester drops reqN in the cycle after ackN. A req still high in the IDLE cycle after DONE counts as a new request.
- lcd_rs/lcd_data stay stable from ISSUE through DONE.

## Timing
- Reset release to first ISSUE: PWRUP_CYCLES+1 cycles.
- req sampled high in IDLE → ISSUE on the next cycle.
- lcd_rdy sampled high in WAIT_HI → DONE next cycle (ack high) → IDLE the cycle after.
- Minimum transaction: ISSUE, one cycle in WAIT_LO, one cycle in WAIT_HI, DONE = 4 cycles. Back-to-back grants are separated by one IDLE cycle.
- lcd_rdy is not registered internally; the controller drives it synchronously on clk.
- nRst asserted mid-transaction: all outputs return to reset values immediately, and the full PWRUP and init sequence repeats. Pending requests are dropped, not acked.

## Configuration
- LCD_SEQ_TIMEOUT_EN defined:
  - The counter restarts at ISSUE and counts in WAIT_LO/WAIT_HI.
  - If it reaches TIMEOUT_CYCLES, set err and go to DONE.
  - In normal phase, ack is still pulsed so the requester does not hang.
  - In init phase, the sequence continues with the next ROM entry.
- LCD_SEQ_TIMEOUT_EN undefined: no watchdog; err tied to 0; WAIT_LO/WAIT_HI wait indefinitely.

## Test plan
- PWRUP_CYCLES=10, controller model drops RDY 3 cycles after strobe and raises it 5 cycles later → exactly 4 strobes carrying 0x38, 0x0C, 0x01, 0x06 with lcd_rs=0, then init_done=1; first strobe 11 cycles after nRst release.
- After init, req0 with rs0=1, data0=0x41 → one strobe with lcd_rs=1, lcd_data=0x41; ack0 pulses once, one cycle after RDY rises; ack1 stays 0.
- req0 and req1 both held continuously (0x10/0x20), dropping each req for one cycle after its ack → grants alternate 0,1,0,1; no requester granted twice in a row.
- req1 asserted during PWRUP → no strobe and no ack1 before init_done; its write is the first strobe after init.
- nRst pulsed low while in WAIT_HI → lcd_nCS=lcd_nWR=1, init_done=0, ack0=0 immediately; the full init sequence reruns.
- LCD_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, model never raises RDY → err=1 and ack0 pulses 16 cycles after ISSUE; state returns to IDLE.
